rx_cw_dw: RTL
=============

# rx_cw_dw

Serial word receiver for the Lab406AD link. It is the far end of the transmitter that frames command words (CW) and data words (DW) under `txen`. The block takes the oversampled Manchester-II line plus the frame enable and recognises the 3-bit-time sync (CW or DW type). It then deserialises 16 data bits MSB-first plus an odd-parity bit and presents the word in parallel with a one-cycle ready strobe and error flag.

## Interface
- `H`, 8: clocks per half-bit; even, ≥4; one bit time = 2·H clocks.
- `TOL`, 2: sync run-length tolerance in clocks, ±TOL around 3·H.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `txen`  in  1  frame enable from line side; word reception only while high.
- `rxd`  in  1  Manchester-II line, asynchronous; bit '1' is high→low at mid-bit, bit '0' is low→high.
- `DAT`  out  16  last completed word's data field, updated even on error.
- `CW_RX`  out  16  last error-free command word.
- `DW_RX`  out  16  last error-free data word.
- `cw`  out  1  type of last completed word: 1 = CW, 0 = DW.
- `rdy`  out  1  one-clock pulse per completed word.
- `err`  out  1  valid with `rdy`: parity or Manchester violation; held until next `rdy`.
- `busy`  out  1  high in any state except IDLE.

## Operation
- `rxd` and `txen` pass through 2-FF synchronisers. All following text refers to the synchronised copies `rs` and `ts`.
- Sync: CW sync is high 3·H clocks then low 3·H. DW sync is low 3·H then high 3·H.
- Word on line: sync, then 17 bit times: D15..D0, then P. Odd parity means ones(D) + P is odd.
- FSM states: IDLE, SYNC1, SYNC2, DATA.
  - IDLE: on `ts`=1, set lvl=`rs` and run=1, go to SYNC1.
  - SYNC1: run++ while `rs`==lvl; run saturates at 3·H+TOL+1.
    - On a transition with run in [3·H−TOL, 3·H+TOL]: latch type=lvl, run=1, go to SYNC2.
    - On a transition with run outside that window: lvl=`rs`, run=1, stay in SYNC1 (this is the resync path).
  - SYNC2: run++.
    - A transition while run < 3·H−TOL means sync failure: lvl=`rs`, run=1, go to SYNC1.
    - When run reaches 3·H: go to DATA with phase p=0 and bit index k=0.
  - DATA: p counts 0..2·H−1.
    - At p=H/2, sample a=`rs`. At p=H+H/2, sample b=`rs`.
    - At p=2·H−1: shift a into the 17-bit shift register; set the sticky Manchester error flag if a==b; then k++.
    - After k=16 (the parity bit) the word completes. Go to SYNC1 with lvl=`rs` and run=1 in the next cycle if `ts`=1, otherwise go to IDLE.
- Completion actions:
  - `DAT`=D and `cw`=type.
  - `err` = manchester_err | ~odd_parity.
  - If err=0: CW_RX=D when type=1, DW_RX=D when type=0.
  - `rdy`=1 for one clock.
- There is no mid-word bit re-timing; the transmitter and receiver share a clock-rate relation exactly.
- `ts` falling in any state: go to IDLE immediately, discard the partial word, no `rdy`, outputs unchanged.
- Reset: state IDLE; all outputs 0; counters and shift register 0.

## Timing
- `rdy`, `DAT`, `CW_RX`/`DW_RX`, `cw` and `err` all update in the same cycle.
- `rdy` rises 3 clocks after the last clock of P's second half on raw `rxd` (2 synchroniser clocks + 1 register stage).
- Back-to-back words: sync run measurement starts on the first clock after P. Consecutive words with no gap are each received, one `rdy` per word.
- `rdy` never asserts in two consecutive cycles. The minimum spacing is 40·H clocks (20 bit times).
- `busy` goes high 3 clocks after raw `txen` rises. It goes low 3 clocks after raw `txen` falls, or 1 clock after word completion when `ts`=0.
- `rst_n` low for one clock mid-word: IDLE on the next edge, no `rdy`, all outputs 0.

## Test plan
- H=8: `txen`=1, CW sync then 0x1234 with P=0 → one `rdy`; CW_RX=0x1234, DAT=0x1234, cw=1, err=0, DW_RX unchanged at 0.
- DW sync then 0xFFFF with P=1, sent back-to-back after the CW above → second `rdy` exactly 320 clocks after the first; DW_RX=0xFFFF, cw=0, err=0, CW_RX still 0x1234.
- CW 0x1234 with P forced to 1 → `rdy` with err=1, DAT=0x1234, CW_RX keeps its previous value.
- Bit D7 sent as constant high for the whole bit time (no mid-bit transition) → err=1 on `rdy`, CW_RX/DW_RX not updated.
- Sync first level of 20 clocks (outside 24±2), then a valid CW 0x00FF → the short sync is rejected, the following valid word is received with err=0, exactly one `rdy`.
- `txen` dropped at bit D4 of a DW → no `rdy`, busy falls 3 clocks later. Separately, `rst_n`=0 at bit D9 → all outputs 0, no `rdy`.

Source files
------------

// File: rtl/rx_cw_dw.sv
// rtl/rx_cw_dw.sv - Manchester-II command/data word receiver
// Ports:
//   clk, rst_n   : clock (rising edge), synchronous active-low reset
//   txen, rxd    : asynchronous frame enable and Manchester-II line
//   DAT          : data field of the last completed word (even on error)
//   CW_RX, DW_RX : last error-free command word / data word
//   cw           : type of last completed word (1 = CW, 0 = DW)
//   rdy          : one-clock pulse per completed word
//   err          : parity or Manchester violation, valid with rdy
//   busy         : receiver is not idle
module rx_cw_dw #(
  parameter int H   = 8,
  parameter int TOL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        txen,
  input  logic        rxd,
  output logic [15:0] DAT,
  output logic [15:0] CW_RX,
  output logic [15:0] DW_RX,
  output logic        cw,
  output logic        rdy,
  output logic        err,
  output logic        busy
);

  localparam int RUNW = $clog2(3*H + TOL + 2);
  localparam int PW   = $clog2(2*H);

  localparam logic [RUNW-1:0] RUN_ONE  = RUNW'(1);
  localparam logic [RUNW-1:0] RUN_LO   = RUNW'(3*H - TOL);
  localparam logic [RUNW-1:0] RUN_HI   = RUNW'(3*H + TOL);
  localparam logic [RUNW-1:0] RUN_SAT  = RUNW'(3*H + TOL + 1);
  localparam logic [RUNW-1:0] RUN_SEND = RUNW'(3*H - 1);
  localparam logic [PW-1:0]   P_A      = PW'(H/2);
  localparam logic [PW-1:0]   P_B      = PW'(H + H/2);
  localparam logic [PW-1:0]   P_END    = PW'(2*H - 1);
  localparam logic [4:0]      K_LAST   = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_SYNC1, S_SYNC2, S_DATA} state_t;

  logic            r_rxd_m, r_rs, r_txen_m, r_ts;
  state_t          r_state, w_state_nxt;
  logic            r_lvl, w_lvl_nxt;
  logic [RUNW-1:0] r_run, w_run_nxt;
  logic            r_type, w_type_nxt;
  logic [PW-1:0]   r_p, w_p_nxt;
  logic [4:0]      r_k, w_k_nxt;
  logic            r_a, w_a_nxt;
  logic            r_b, w_b_nxt;
  logic [15:0]     r_sr, w_sr_nxt;
  logic            r_merr, w_merr_nxt;
  logic            w_done;
  logic            w_trans;
  logic [16:0]     w_sr_shift;
  logic            w_merr_bit;
  logic            w_err;

  logic [15:0]     r_dat, r_cw_rx, r_dw_rx;
  logic            r_cw, r_rdy, r_err;

  // Shift-in of the current bit; at completion this holds D15..D0 followed by P.
  assign w_sr_shift = {r_sr, r_a};
  assign w_merr_bit = r_merr | (r_a == r_b);
  assign w_err      = w_merr_bit | ~(^w_sr_shift);
  assign w_trans    = (r_rs != r_lvl);

  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_run_nxt   = r_run;
    w_type_nxt  = r_type;
    w_p_nxt     = r_p;
    w_k_nxt     = r_k;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_sr_nxt    = r_sr;
    w_merr_nxt  = r_merr;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_ts) begin
          w_lvl_nxt   = r_rs;
          w_run_nxt   = RUN_ONE;
          w_state_nxt = S_SYNC1;
        end
      end

      S_SYNC1: begin
        if (!w_trans) begin
          if (r_run != RUN_SAT) begin
            w_run_nxt = r_run + RUN_ONE;
          end
        end else if (r_run >= RUN_LO && r_run <= RUN_HI) begin
          w_type_nxt  = r_lvl;
          w_lvl_nxt   = r_rs;
          w_run_nxt   = RUN_ONE;
          w_state_nxt = S_SYNC2;
        end else begin
          w_lvl_nxt = r_rs;
          w_run_nxt = RUN_ONE;
        end
      end

      S_SYNC2: begin
        if (w_trans && r_run < RUN_LO) begin
          w_lvl_nxt   = r_rs;
          w_run_nxt   = RUN_ONE;
          w_state_nxt = S_SYNC1;
        end else if (r_run == RUN_SEND) begin
          // This edge consumes the last sample of the second sync level.
          w_state_nxt = S_DATA;
          w_run_nxt   = '0;
          w_p_nxt     = '0;
          w_k_nxt     = '0;
          w_merr_nxt  = 1'b0;
        end else begin
          w_run_nxt = r_run + RUN_ONE;
        end
      end

      S_DATA: begin
        if (r_p == P_A) w_a_nxt = r_rs;
        if (r_p == P_B) w_b_nxt = r_rs;
        if (r_p == P_END) begin
          w_p_nxt    = '0;
          w_sr_nxt   = w_sr_shift[15:0];
          w_merr_nxt = w_merr_bit;
          if (r_k == K_LAST) begin
            w_done   = 1'b1;
            w_k_nxt  = '0;
            w_sr_nxt = '0;
            if (r_ts) begin
              // run=0 with lvl = last P sample: the next sample either
              // extends this level (run becomes 1) or resyncs to a new one.
              w_state_nxt = S_SYNC1;
              w_lvl_nxt   = r_rs;
              w_run_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_k_nxt = r_k + 5'd1;
          end
        end else begin
          w_p_nxt = r_p + PW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // Frame enable gone: abandon whatever was in progress.
    if (!r_ts && !w_done) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rxd_m  <= 1'b0;
      r_rs     <= 1'b0;
      r_txen_m <= 1'b0;
      r_ts     <= 1'b0;
      r_state  <= S_IDLE;
      r_lvl    <= 1'b0;
      r_run    <= '0;
      r_type   <= 1'b0;
      r_p      <= '0;
      r_k      <= '0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_sr     <= '0;
      r_merr   <= 1'b0;
      r_dat    <= '0;
      r_cw_rx  <= '0;
      r_dw_rx  <= '0;
      r_cw     <= 1'b0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rxd_m  <= rxd;
      r_rs     <= r_rxd_m;
      r_txen_m <= txen;
      r_ts     <= r_txen_m;
      r_state  <= w_state_nxt;
      r_lvl    <= w_lvl_nxt;
      r_run    <= w_run_nxt;
      r_type   <= w_type_nxt;
      r_p      <= w_p_nxt;
      r_k      <= w_k_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_sr     <= w_sr_nxt;
      r_merr   <= w_merr_nxt;
      r_rdy    <= w_done;
      if (w_done) begin
        r_dat <= w_sr_shift[16:1];
        r_cw  <= r_type;
        r_err <= w_err;
        if (!w_err) begin
          if (r_type) r_cw_rx <= w_sr_shift[16:1];
          else        r_dw_rx <= w_sr_shift[16:1];
        end
      end
    end
  end

  assign DAT   = r_dat;
  assign CW_RX = r_cw_rx;
  assign DW_RX = r_dw_rx;
  assign cw    = r_cw;
  assign rdy   = r_rdy;
  assign err   = r_err;
  assign busy  = (r_state != S_IDLE);

endmodule
